// File: rtl/program_loader_pkg.sv
// Shared types and constants for the boot program loader.
package program_loader_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned BYTE_W = 8;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    LOAD_DATA = 2'd0,
    LOAD_INST = 2'd1,
    RUN       = 2'd2
  } state_e;

  localparam word_t DELIM = 32'hFFFF_FFFF;

endpackage

// File: rtl/program_loader_if.sv
// UART byte input, start button and memory write ports of the program loader.
interface program_loader_if
  import program_loader_pkg::*;
#(
  parameter int unsigned DMEM_AW = 12,
  parameter int unsigned IMEM_AW = 12
);

  logic                rx_valid;
  logic [BYTE_W-1:0]   rx_data;
  logic                START_EXEC;
  logic                dmem_we;
  logic [DMEM_AW-1:0]  dmem_addr;
  logic                imem_we;
  logic [IMEM_AW-1:0]  imem_addr;
  word_t               wdata;
  logic                cpu_rst_n;
  logic [IMEM_AW:0]    inst_count;
  logic [7:0]          state_led;

  // Environment side: UART receiver, button, memories.
  modport master (
    output rx_valid, rx_data, START_EXEC,
    input  dmem_we, dmem_addr, imem_we, imem_addr, wdata,
           cpu_rst_n, inst_count, state_led
  );

  // Loader side.
  modport slave (
    input  rx_valid, rx_data, START_EXEC,
    output dmem_we, dmem_addr, imem_we, imem_addr, wdata,
           cpu_rst_n, inst_count, state_led
  );

endinterface

// File: rtl/program_loader_word_assembler.sv
// Big-endian byte-to-word assembly: first byte received lands in bits [31:24].
module program_loader_word_assembler
  import program_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              valid_i,
  input  logic [BYTE_W-1:0] data_i,
  input  logic              flush_i,
  output logic              word_valid_c_o,
  output word_t             word_c_o,
  output logic [1:0]        byte_cnt_o
);

  logic [23:0] sreg_q;
  logic [1:0]  cnt_q;

  // Flush discards a partial word and has priority over an incoming byte.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (flush_i) begin
      sreg_q <= '0;
      cnt_q  <= '0;
    end else if (valid_i) begin
      sreg_q <= {sreg_q[15:0], data_i};
      cnt_q  <= cnt_q + 2'd1;
    end
  end

  assign word_valid_c_o = valid_i && (cnt_q == 2'd3);
  assign word_c_o       = {sreg_q, data_i};
  assign byte_cnt_o     = cnt_q;

endmodule

// File: rtl/program_loader.sv
// Boot sequencer: loads data then instruction words from UART and releases the core.
module program_loader
  import program_loader_pkg::*;
#(
  parameter int unsigned DMEM_AW = 12,
  parameter int unsigned IMEM_AW = 12,
  parameter logic [31:0] DELIM   = program_loader_pkg::DELIM
)(
  input  logic            CLK,
  input  logic            RST_N,
  program_loader_if.slave bus
);

  localparam int unsigned DPTR_W = DMEM_AW + 1;
  localparam int unsigned IPTR_W = IMEM_AW + 1;

  state_e              state_q, state_d;
  logic [DPTR_W-1:0]   dptr_q, dptr_d;
  logic [IPTR_W-1:0]   iptr_q, iptr_d;
  logic                dmem_we_q, dmem_we_d;
  logic                imem_we_q, imem_we_d;
  logic [DMEM_AW-1:0]  dmem_addr_q, dmem_addr_d;
  logic [IMEM_AW-1:0]  imem_addr_q, imem_addr_d;
  word_t               wdata_q, wdata_d;
  logic                cpu_rst_n_q, cpu_rst_n_d;
  logic                ovf_q, ovf_d;
  logic                ferr_q, ferr_d;
  logic                start_q;

  logic                start_edge_c;
  logic                asm_valid_c;
  logic                flush_c;
  logic                word_valid_c;
  word_t               word_c;
  logic [1:0]          byte_cnt;

  assign start_edge_c = bus.START_EXEC && !start_q;
  assign asm_valid_c  = bus.rx_valid && (state_q != RUN);
  assign flush_c      = start_edge_c && (state_q == LOAD_INST);

  program_loader_word_assembler u_asm (
    .clk            (CLK),
    .rst_n          (RST_N),
    .valid_i        (asm_valid_c),
    .data_i         (bus.rx_data),
    .flush_i        (flush_c),
    .word_valid_c_o (word_valid_c),
    .word_c_o       (word_c),
    .byte_cnt_o     (byte_cnt)
  );

  always_comb begin
    state_d     = state_q;
    dptr_d      = dptr_q;
    iptr_d      = iptr_q;
    dmem_we_d   = 1'b0;
    imem_we_d   = 1'b0;
    dmem_addr_d = dmem_addr_q;
    imem_addr_d = imem_addr_q;
    wdata_d     = wdata_q;
    ovf_d       = ovf_q;
    ferr_d      = ferr_q;

    case (state_q)
      LOAD_DATA: begin
        // A start edge here is ignored: nothing is loaded yet.
        if (word_valid_c) begin
          if (word_c == DELIM) begin
            state_d = LOAD_INST;
          end else if (dptr_q[DMEM_AW]) begin
            ovf_d = 1'b1;
          end else begin
            dmem_we_d   = 1'b1;
            dmem_addr_d = dptr_q[DMEM_AW-1:0];
            wdata_d     = word_c;
            dptr_d      = dptr_q + DPTR_W'(1);
          end
        end
      end
      LOAD_INST: begin
        if (word_valid_c) begin
          if (iptr_q[IMEM_AW]) begin
            ovf_d = 1'b1;
          end else begin
            imem_we_d   = 1'b1;
            imem_addr_d = iptr_q[IMEM_AW-1:0];
            wdata_d     = word_c;
            iptr_d      = iptr_q + IPTR_W'(1);
          end
        end
        // A word completing on the edge cycle leaves no partial word behind.
        if (start_edge_c) begin
          state_d = RUN;
          if ((byte_cnt != 2'd0) && !word_valid_c) begin
            ferr_d = 1'b1;
          end
        end
      end
      RUN: begin
      end
      default: state_d = LOAD_DATA;
    endcase

    cpu_rst_n_d = (state_d == RUN);
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= LOAD_DATA;
      dptr_q      <= '0;
      iptr_q      <= '0;
      dmem_we_q   <= 1'b0;
      imem_we_q   <= 1'b0;
      dmem_addr_q <= '0;
      imem_addr_q <= '0;
      wdata_q     <= '0;
      cpu_rst_n_q <= 1'b0;
      ovf_q       <= 1'b0;
      ferr_q      <= 1'b0;
      start_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dptr_q      <= dptr_d;
      iptr_q      <= iptr_d;
      dmem_we_q   <= dmem_we_d;
      imem_we_q   <= imem_we_d;
      dmem_addr_q <= dmem_addr_d;
      imem_addr_q <= imem_addr_d;
      wdata_q     <= wdata_d;
      cpu_rst_n_q <= cpu_rst_n_d;
      ovf_q       <= ovf_d;
      ferr_q      <= ferr_d;
      start_q     <= bus.START_EXEC;
    end
  end

  assign bus.dmem_we    = dmem_we_q;
  assign bus.dmem_addr  = dmem_addr_q;
  assign bus.imem_we    = imem_we_q;
  assign bus.imem_addr  = imem_addr_q;
  assign bus.wdata      = wdata_q;
  assign bus.cpu_rst_n  = cpu_rst_n_q;
  assign bus.inst_count = iptr_q;
  assign bus.state_led  = {ovf_q, ferr_q, 4'b0000, state_q};

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: two instances (IMEM_AW=12 and IMEM_AW=2) share one stimulus stream.
module tb_program_loader;
  import program_loader_pkg::*;

  typedef struct {
    bit          is_imem;
    int          addr;
    logic [31:0] data;
  } exp_t;

  logic       CLK = 1'b0;
  logic       RST_N = 1'b0;
  logic       rx_valid = 1'b0;
  logic [7:0] rx_data = 8'h00;
  logic       start = 1'b0;

  always #5 CLK = ~CLK;

  program_loader_if #(.DMEM_AW(12), .IMEM_AW(12)) bus0 ();
  program_loader_if #(.DMEM_AW(12), .IMEM_AW(2))  bus1 ();

  assign bus0.rx_valid   = rx_valid;
  assign bus0.rx_data    = rx_data;
  assign bus0.START_EXEC = start;
  assign bus1.rx_valid   = rx_valid;
  assign bus1.rx_data    = rx_data;
  assign bus1.START_EXEC = start;

  program_loader #(.DMEM_AW(12), .IMEM_AW(12), .DELIM(DELIM)) u_dut0 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus0.slave));
  program_loader #(.DMEM_AW(12), .IMEM_AW(2), .DELIM(DELIM)) u_dut1 (
    .CLK(CLK), .RST_N(RST_N), .bus(bus1.slave));

  int checks = 0;
  int failures = 0;

  exp_t q0[$];
  exp_t q1[$];

  // Reference model: phase 0=loading data, 1=loading instructions, 2=running.
  int          aw[2] = '{12, 2};
  int          phase[2];
  int          dptr[2];
  int          iptr[2];
  bit          ovf[2];
  bit          ferr[2];
  int          pcnt[2];
  logic [31:0] pacc[2];
  bit          prev_s = 1'b0;

  function automatic void chk(string name, int k, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s dut%0d actual=%h expected=%h", name, k, act, exp);
    end
  endfunction

  function automatic void push_exp(int k, bit is_imem, int addr, logic [31:0] data);
    exp_t e;
    e.is_imem = is_imem;
    e.addr = addr;
    e.data = data;
    if (k == 0) q0.push_back(e);
    else q1.push_back(e);
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      phase[k] = 0; dptr[k] = 0; iptr[k] = 0;
      ovf[k] = 0; ferr[k] = 0; pcnt[k] = 0; pacc[k] = '0;
    end
    prev_s = 1'b0;
  endfunction

  function automatic void model_word(int k, logic [31:0] w);
    if (phase[k] == 0) begin
      if (w == DELIM) phase[k] = 1;
      else if (dptr[k] < 4096) begin push_exp(k, 1'b0, dptr[k], w); dptr[k]++; end
      else ovf[k] = 1;
    end else begin
      if (iptr[k] < (1 << aw[k])) begin push_exp(k, 1'b1, iptr[k], w); iptr[k]++; end
      else ovf[k] = 1;
    end
  endfunction

  function automatic void model_step(int k, bit v, logic [7:0] b, bit edge_s);
    int old;
    old = phase[k];
    if (v && old != 2) begin
      pacc[k] = (pacc[k] << 8) | 32'(b);
      pcnt[k]++;
      if (pcnt[k] == 4) begin
        model_word(k, pacc[k]);
        pcnt[k] = 0;
        pacc[k] = '0;
      end
    end
    if (edge_s && old == 1) begin
      if (pcnt[k] != 0) ferr[k] = 1;
      pcnt[k] = 0;
      pacc[k] = '0;
      phase[k] = 2;
    end
  endfunction

  task automatic mon(int k, logic dwe, logic iwe, int daddr, int iaddr, logic [31:0] wd);
    exp_t e;
    if (dwe && iwe) begin
      checks++; failures++;
      $display("FAIL both_we dut%0d actual=11 expected=one_hot", k);
    end
    if (dwe || iwe) begin
      if ((k == 0 && q0.size() == 0) || (k == 1 && q1.size() == 0)) begin
        checks++; failures++;
        $display("FAIL unexpected_write dut%0d actual=imem%0b addr=%0d data=%h expected=none", k, iwe, iwe ? iaddr : daddr, wd);
      end else begin
        e = (k == 0) ? q0.pop_front() : q1.pop_front();
        chk("write_target", k, 32'(iwe), 32'(e.is_imem));
        chk("write_addr", k, iwe ? iaddr : daddr, e.addr);
        chk("write_data", k, wd, e.data);
      end
    end
  endtask

  always @(negedge CLK) begin
    mon(0, bus0.dmem_we, bus0.imem_we, 32'(bus0.dmem_addr), 32'(bus0.imem_addr), bus0.wdata);
    mon(1, bus1.dmem_we, bus1.imem_we, 32'(bus1.dmem_addr), 32'(bus1.imem_addr), bus1.wdata);
  end

  task automatic cycle(bit v, logic [7:0] b, bit s);
    bit e;
    @(negedge CLK);
    rx_valid = v;
    rx_data = b;
    start = s;
    e = s && !prev_s;
    prev_s = s;
    model_step(0, v, b, e);
    model_step(1, v, b, e);
    @(posedge CLK);
    #1 rx_valid = 1'b0;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 8'h00, prev_s);
  endtask

  task automatic send_byte(logic [7:0] b, bit s);
    cycle(1'b1, b, s);
    if ($urandom_range(0, 3) == 0) idle(1);
  endtask

  // Bytes go out most significant first; the start level may be raised on the last byte.
  task automatic send_word(logic [31:0] w, bit s_last);
    logic [31:0] t;
    t = w;
    for (int i = 0; i < 4; i++) begin
      send_byte(t[31:24], (i == 3) ? s_last : prev_s);
      t = t << 8;
    end
  endtask

  task automatic pulse_start();
    cycle(1'b0, 8'h00, 1'b1);
  endtask

  task automatic chk_status(string tag);
    logic [7:0] led;
    @(negedge CLK);
    for (int k = 0; k < 2; k++) begin
      led = {ovf[k], ferr[k], 4'b0000, 2'(phase[k])};
      chk({tag, "_state_led"}, k, (k == 0) ? 32'(bus0.state_led) : 32'(bus1.state_led), 32'(led));
      chk({tag, "_inst_count"}, k, (k == 0) ? 32'(bus0.inst_count) : 32'(bus1.inst_count), iptr[k]);
      chk({tag, "_cpu_rst_n"}, k, (k == 0) ? 32'(bus0.cpu_rst_n) : 32'(bus1.cpu_rst_n), 32'(phase[k] == 2));
    end
  endtask

  task automatic chk_reset_outputs(string tag);
    chk({tag, "_rst_d0"}, 0, {bus0.dmem_we, bus0.imem_we, bus0.cpu_rst_n, bus0.state_led, 13'(bus0.inst_count)}, '0);
    chk({tag, "_rst_a0"}, 0, {8'h0, 12'(bus0.dmem_addr), 12'(bus0.imem_addr)}, '0);
    chk({tag, "_rst_w0"}, 0, bus0.wdata, '0);
    chk({tag, "_rst_d1"}, 1, {bus1.dmem_we, bus1.imem_we, bus1.cpu_rst_n, bus1.state_led, 3'(bus1.inst_count)}, '0);
    chk({tag, "_rst_w1"}, 1, bus1.wdata, '0);
  endtask

  // Asynchronous reset applied away from the clock edge; outputs must clear before any edge.
  task automatic do_reset(string tag);
    chk({tag, "_drained"}, 0, q0.size(), 0);
    chk({tag, "_drained"}, 1, q1.size(), 0);
    @(negedge CLK);
    rx_valid = 1'b0;
    start = 1'b0;
    #2 RST_N = 1'b0;
    #1 chk_reset_outputs(tag);
    model_reset();
    q0.delete();
    q1.delete();
    @(negedge CLK);
    #1 RST_N = 1'b1;
  endtask

  initial begin
    model_reset();
    #12 chk_reset_outputs("por");
    @(negedge CLK);
    #1 RST_N = 1'b1;

    // Basic load: three data words, delimiter, two instructions, start.
    send_word(32'h0000_0000, 1'b0);
    send_word(32'h3F80_0000, 1'b0);
    send_word(32'h4049_0FDB, 1'b0);
    send_word(DELIM, 1'b0);
    send_word(32'h4F84_E200, 1'b0);
    send_word(32'h4C40_0280, 1'b0);
    idle(1);
    chk_status("loaded");
    pulse_start();
    chk_status("run_entry");
    cycle(1'b0, 8'h00, 1'b0);

    // Start edge while still loading data is ignored.
    do_reset("t2");
    send_word(32'h1234_5678, 1'b0);
    pulse_start();
    chk_status("edge_in_data");
    cycle(1'b0, 8'h00, 1'b0);
    send_word(DELIM, 1'b0);
    pulse_start();
    chk_status("edge_after_delim");
    cycle(1'b0, 8'h00, 1'b0);

    // Delimiter value is a legal instruction; a dangling byte raises frame_err.
    do_reset("t3");
    send_word(DELIM, 1'b0);
    send_word(32'hFFFF_FFFF, 1'b0);
    send_byte(8'hAB, 1'b0);
    pulse_start();
    chk_status("frame_err");
    cycle(1'b0, 8'h00, 1'b0);

    // Instruction overflow on the small instance.
    do_reset("t4");
    send_word(DELIM, 1'b0);
    for (int i = 0; i < 5; i++) send_word(32'hA000_0000 + 32'(i), 1'b0);
    idle(1);
    chk_status("overflow");

    // Reset mid-word, then a fresh word lands at dmem 0.
    do_reset("t5");
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    do_reset("t5_mid");
    send_word(32'hCAFE_BABE, 1'b0);
    idle(1);
    chk_status("after_mid_reset");

    // Running: bytes and a held start are ignored.
    do_reset("t6");
    send_word(DELIM, 1'b0);
    send_word(32'h0000_0013, 1'b0);
    pulse_start();
    for (int i = 0; i < 8; i++) send_byte(8'($urandom), 1'b1);
    idle(10);
    chk_status("run_quiet");

    // Coincident events: delimiter with edge, then word completion with edge.
    do_reset("t7");
    send_word(32'h0BAD_F00D, 1'b0);
    send_word(DELIM, 1'b1);
    cycle(1'b0, 8'h00, 1'b0);
    chk_status("delim_edge_lost");
    send_word(32'h7777_0001, 1'b1);
    chk_status("word_edge_run");
    cycle(1'b0, 8'h00, 1'b0);

    // Randomized images.
    for (int it = 0; it < 8; it++) begin
      int nd, ni, nx;
      do_reset("rnd");
      nd = $urandom_range(0, 4);
      ni = $urandom_range(0, 6);
      nx = $urandom_range(0, 3);
      for (int i = 0; i < nd; i++) send_word($urandom, 1'b0);
      send_word(DELIM, 1'b0);
      for (int i = 0; i < ni; i++) send_word($urandom, 1'b0);
      for (int i = 0; i < nx; i++) send_byte(8'($urandom), 1'b0);
      idle(1);
      chk_status("rnd_loaded");
      pulse_start();
      chk_status("rnd_run");
      for (int i = 0; i < 3; i++) send_byte(8'($urandom), 1'b0);
      idle(2);
      chk_status("rnd_after");
    end

    idle(2);
    chk("final_queue", 0, q0.size(), 0);
    chk("final_queue", 1, q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/program_loader.md
Name: program_loader

Overview:
- Sequences CPU boot. Receives the program image over UART, assembles the bytes into 32-bit words, and writes them into data memory and instruction memory.
- The image has a data section, then the delimiter word, then the instruction section. The block releases the core when START_EXEC rises.
- Sits between the UART receiver and the core's memory write ports. The core's pipeline reset comes from this block.

Parameters:
- DMEM_AW, 12, data-memory word-address width.
- IMEM_AW, 12, instruction-memory word-address width.
- DELIM, 32'hFFFF_FFFF, section delimiter word.

Ports:
- CLK  in  1  system clock.
- RST_N  in  1  asynchronous active-low reset.
- rx_valid  in  1  one-cycle strobe: a received UART byte is valid.
- rx_data  in  8  received byte.
- START_EXEC  in  1  level input from the board button; the block edge-detects it internally.
- dmem_we  out  1  data-memory write enable.
- dmem_addr  out  DMEM_AW  data-memory write address.
- imem_we  out  1  instruction-memory write enable.
- imem_addr  out  IMEM_AW  instruction-memory write address.
- wdata  out  32  write data, shared by both memories.
- cpu_rst_n  out  1  core reset; low until the RUN state.
- inst_count  out  IMEM_AW+1  number of instruction words loaded.
- state_led  out  8  {overflow, frame_err, 4'b0, state[1:0]}.

Behaviour:
- Reset (async, RST_N low), all registers cleared:
  - state=LOAD_DATA, byte_cnt=0, word shift register=0.
  - addresses=0, we=0, wdata=0, inst_count=0.
  - cpu_rst_n=0, overflow=0, frame_err=0, start edge register=0.
  - Reset mid-load abandons the partial word. Memory contents are not cleared.
- Byte assembly: on rx_valid, shift {sreg[23:0], rx_data} and increment the 2-bit byte_cnt. The first byte received is bits [31:24].
  - On the 4th byte (byte_cnt==3 while rx_valid), the completed word is {sreg[23:0], rx_data}. byte_cnt wraps to 0.
- Word handling, all effects registered (1-cycle latency from the 4th byte's rx_valid to the write strobe):
  - LOAD_DATA, word==DELIM: no write; next state LOAD_INST.
  - LOAD_DATA, any other word: dmem_we=1 for one cycle with wdata=word and dmem_addr=current data pointer. The pointer increments after the write.
  - LOAD_INST, any word (DELIM included, which is written as data): imem_we=1, wdata=word, imem_addr=pointer. Then the pointer increments and inst_count increments.
  - Pointer full (pointer reached 2^AW): no write; overflow is set sticky. The pointer saturates and inst_count saturates at 2^IMEM_AW.
- START_EXEC handling:
  - Rising edge = START_EXEC high and previous-cycle START_EXEC low. The edge register updates every cycle.
  - Edge in LOAD_INST: go to RUN. If byte_cnt!=0, the partial word is discarded, byte_cnt=0, and frame_err is set sticky.
  - Edge in LOAD_DATA: ignored (no program loaded yet).
  - Edge in RUN: ignored; holding START_EXEC high for multiple cycles has no further effect.
- RUN:
  - cpu_rst_n=1 registered, i.e. high the cycle after the RUN entry edge.
  - rx_valid is ignored. No memory writes occur.
  - The only exit is RST_N.
- States (2-bit): LOAD_DATA=0, LOAD_INST=1, RUN=2; 3 is unused and recovers to LOAD_DATA.
- Simultaneous events:
  - rx_valid completing a word in the same cycle as a START_EXEC edge in LOAD_INST: the word is written, then the block enters RUN. byte_cnt is 0 after that word, so frame_err is not set.
  - 4th byte = DELIM in the same cycle as a START_EXEC edge in LOAD_DATA: the block enters LOAD_INST only; the edge is lost.
- dmem_we and imem_we are never high in the same cycle. Each write strobe is high for exactly one cycle per word.

Decomposition:
- Shared package (loader_pkg): state enum typedef {LOAD_DATA, LOAD_INST, RUN}, the DELIM constant, and a word_t 32-bit typedef.
- One natural sub-module: word_assembler. Byte-to-word shift register plus byte_cnt, outputs word_valid and word.
- The FSM, pointers and start edge detection live in program_loader.

Test Plan:
- Data/instructions: 3 data words (0x00000000, 0x3F800000, 0x40490FDB), DELIM, 2 instructions (0x4F84E200, 0x4C400280), START_EXEC edge. Expect:
  - dmem writes at addresses 0,1,2 with those values;
  - no write for DELIM;
  - imem writes at 0,1;
  - inst_count=2;
  - cpu_rst_n high 1 cycle after the edge.
- START_EXEC pulsed in LOAD_DATA after 1 data word: state remains LOAD_DATA and cpu_rst_n=0. After DELIM then an edge: RUN.
- DELIM then 0xFFFFFFFF then 1 extra byte 0xAB, then an edge: imem[0]=0xFFFFFFFF, inst_count=1, frame_err=1, RUN.
- IMEM_AW=2, DELIM then 5 instructions: writes at imem 0..3 only; overflow=1; inst_count=4.
- RST_N asserted after 2 bytes of a data word: all outputs return to reset values immediately (async). A fresh 4-byte word is then written at dmem address 0.
- In RUN, send 8 bytes and hold START_EXEC high for 10 cycles: no dmem_we/imem_we pulses; state stays RUN.
